// File: rtl/i2c_target_rsp_if.sv
// Bus-side signals of the I2C target responder: raw SCL/SDA in, open-drain SDA out,
// transaction status and the register-file write strobe.
interface i2c_target_rsp_if #(
  parameter int PW = 4
);
  logic          scl_i;
  logic          sda_i;
  logic          sda_o;
  logic          busy_o;
  logic          wr_stb_o;
  logic [PW-1:0] wr_adr_o;
  logic [7:0]    wr_dat_o;

  modport master (
    output scl_i, sda_i,
    input  sda_o, busy_o, wr_stb_o, wr_adr_o, wr_dat_o
  );

  modport slave (
    input  scl_i, sda_i,
    output sda_o, busy_o, wr_stb_o, wr_adr_o, wr_dat_o
  );
endinterface

// File: rtl/i2c_target_rsp.sv
// I2C target with a 7-bit address and a small register file: the first written byte
// sets the pointer, later bytes are stored; reads stream bytes from the pointer.
module i2c_target_rsp #(
  parameter logic [6:0] SLAVE_ADDR = 7'h22,
  parameter int         MEM_DEPTH  = 16
) (
  input logic             clk_i,
  input logic             rst_i,
  i2c_target_rsp_if.slave bus
);
  localparam int PW = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_IGNORE, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK
  } state_t;

  state_t        state, state_nxt;
  logic          scl_p0, scl_p1, scl_p2;
  logic          sda_p0, sda_p1, sda_p2;
  logic          scl_rise, scl_fall, start_det, stop_det;
  logic [2:0]    bit_cnt;
  logic [7:0]    sr;
  logic          rw;
  logic          first_byte;
  logic [PW-1:0] ptr;
  logic [7:0]    mem [MEM_DEPTH];
  logic          sda_q, wr_stb_q;
  logic [PW-1:0] wr_adr_q;
  logic [7:0]    wr_dat_q;
  logic          busy;
  logic          act_shift_in, act_addr_done, act_ack, act_release;
  logic          act_load, act_shift_out, act_commit, act_rd_acked;

  // Stage p0/p1: two-flop synchronizers; p2: previous synchronized value for edges
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_p0 <= 1'b1; scl_p1 <= 1'b1; scl_p2 <= 1'b1;
      sda_p0 <= 1'b1; sda_p1 <= 1'b1; sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= bus.scl_i; scl_p1 <= scl_p0; scl_p2 <= scl_p1;
      sda_p0 <= bus.sda_i; sda_p1 <= sda_p0; sda_p2 <= sda_p1;
    end
  end

  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start_det) begin
      state_nxt = S_ADDR;
    end else if (stop_det) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_ADDR:     if (scl_rise && bit_cnt == 3'd7)
                      state_nxt = (sr[6:0] == SLAVE_ADDR) ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK: if (scl_fall && bit_cnt == 3'd1)
                      state_nxt = rw ? S_RD_BYTE : S_WR_BYTE;
        S_WR_BYTE:  if (scl_rise && bit_cnt == 3'd7) state_nxt = S_WR_ACK;
        S_WR_ACK:   if (scl_fall && bit_cnt == 3'd2) state_nxt = S_WR_BYTE;
        S_RD_BYTE:  if (scl_fall && bit_cnt == 3'd7) state_nxt = S_RD_ACK;
        S_RD_ACK: begin
          if (scl_rise && bit_cnt == 3'd0 && sda_p1) state_nxt = S_IGNORE;
          else if (scl_fall && bit_cnt == 3'd1)      state_nxt = S_RD_BYTE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Per-state actions; bit_cnt also sequences the sub-phases of the ACK slots
  always_comb begin
    busy          = state inside {S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK};
    act_shift_in  = 1'b0;
    act_addr_done = 1'b0;
    act_ack       = 1'b0;
    act_release   = 1'b0;
    act_load      = 1'b0;
    act_shift_out = 1'b0;
    act_commit    = 1'b0;
    act_rd_acked  = 1'b0;
    if (!start_det && !stop_det) begin
      case (state)
        S_ADDR: if (scl_rise) begin
          act_shift_in  = 1'b1;
          act_addr_done = (bit_cnt == 3'd7);
        end
        S_WR_BYTE: act_shift_in = scl_rise;
        S_ADDR_ACK: if (scl_fall) begin
          if (bit_cnt == 3'd0) act_ack = 1'b1;
          else if (rw)         act_load = 1'b1;
          else                 act_release = 1'b1;
        end
        S_WR_ACK: begin
          if (scl_fall && bit_cnt == 3'd0) act_ack = 1'b1;
          if (scl_fall && bit_cnt == 3'd2) act_release = 1'b1;
          if (scl_rise && bit_cnt == 3'd1) act_commit = 1'b1;
        end
        S_RD_BYTE: if (scl_fall) begin
          if (bit_cnt == 3'd7) act_release = 1'b1;
          else                 act_shift_out = 1'b1;
        end
        S_RD_ACK: begin
          if (scl_rise && bit_cnt == 3'd0 && !sda_p1) act_rd_acked = 1'b1;
          if (scl_fall && bit_cnt == 3'd1)            act_load = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sda_q      <= 1'b1;
      wr_stb_q   <= 1'b0;
      wr_adr_q   <= '0;
      wr_dat_q   <= '0;
      ptr        <= '0;
      first_byte <= 1'b1;
      bit_cnt    <= '0;
      sr         <= '0;
      rw         <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_stb_q <= 1'b0;
      if (start_det || stop_det) begin
        sda_q   <= 1'b1;
        bit_cnt <= '0;
        if (start_det) first_byte <= 1'b1;
      end
      if (act_shift_in) begin
        sr      <= {sr[6:0], sda_p1};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (act_addr_done) rw <= sda_p1;
      if (act_ack) begin
        sda_q   <= 1'b0;
        bit_cnt <= 3'd1;
      end
      if (act_release) begin
        sda_q   <= 1'b1;
        bit_cnt <= '0;
      end
      // Pointer advances as the byte is loaded, so the next ACKed byte is already addressed
      if (act_load) begin
        sr      <= mem[ptr];
        sda_q   <= mem[ptr][7];
        ptr     <= ptr + 1'b1;
        bit_cnt <= '0;
      end
      if (act_shift_out) begin
        sr      <= {sr[6:0], 1'b0};
        sda_q   <= sr[6];
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (act_rd_acked) bit_cnt <= 3'd1;
      if (act_commit) begin
        bit_cnt <= 3'd2;
        if (first_byte) begin
          ptr        <= sr[PW-1:0];
          first_byte <= 1'b0;
        end else begin
          mem[ptr] <= sr;
          wr_stb_q <= 1'b1;
          wr_adr_q <= ptr;
          wr_dat_q <= sr;
          ptr      <= ptr + 1'b1;
        end
      end
    end
  end

  assign bus.sda_o    = sda_q;
  assign bus.busy_o   = busy;
  assign bus.wr_stb_o = wr_stb_q;
  assign bus.wr_adr_o = wr_adr_q;
  assign bus.wr_dat_o = wr_dat_q;
endmodule

// File: doc/i2c_target_rsp.md
# i2c_target_rsp

Synthesizable I2C target (responder) for the far end of an I2C bus driven by the multi-bus controller. It recognises START/STOP and its 7-bit address, ACKs the address, and exposes a 16-byte register file. Writes set a pointer and store data; reads return data from the pointer. Used in loopback/emulation builds as a hardware stand-in for the behavioural I2C slave model.

## Interface
- SLAVE_ADDR, 7'h22: 7-bit target address.
- MEM_DEPTH, 16: register-file bytes (power of 2); pointer width PW = log2(MEM_DEPTH) = 4.
- clk_i  in  1  system clock; must be ≥ 8× SCL frequency.
- rst_i  in  1  reset, synchronous, active-high.
- scl_i  in  1  bus SCL (never driven; no clock stretching).
- sda_i  in  1  bus SDA.
- sda_o  out  1  open-drain SDA drive: 0 = pull low, 1 = release.
- busy_o  out  1  high from address match until STOP/START/mismatch end.
- wr_stb_o  out  1  one-cycle pulse per stored data byte.
- wr_adr_o  out  PW  register index written on wr_stb_o.
- wr_dat_o  out  8  byte written on wr_stb_o.

## Operation
- scl_i and sda_i pass through 2-FF synchronizers, then a registered copy for edge detection. All decisions use the synchronized values.
- START (sync SDA falls while SCL high): from any state -> ADDR, bit count = 0, first_byte = 1. This also covers repeated START. The pointer is kept.
- STOP (sync SDA rises while SCL high): from any state -> IDLE, sda_o = 1, busy_o = 0.
- Bits are sampled on the sync SCL rising edge, MSB first. sda_o changes only on the cycle after a sync SCL falling edge is detected.
- States:
  - IDLE: sda_o = 1. Waits for START.
  - ADDR: shifts 8 bits. After the 8th rising edge:
    - addr[7:1] == SLAVE_ADDR -> ADDR_ACK, busy_o = 1, rw = bit0.
    - otherwise -> IGNORE.
  - IGNORE: sda_o = 1 until START/STOP.
  - ADDR_ACK: on the next SCL fall, drive sda_o = 0. On the following SCL fall, go to WR_BYTE (rw = 0) or RD_BYTE (rw = 1).
  - Entering RD_BYTE: load shift register from mem[ptr] and drive bit 7 immediately.
  - WR_BYTE: shifts 8 bits, then -> WR_ACK.
  - WR_ACK: drives ACK for one SCL low/high phase. Then:
    - first_byte = 1: ptr <= byte[PW-1:0], first_byte <= 0. Upper bits are ignored.
    - otherwise: mem[ptr] <= byte, pulse wr_stb_o (wr_adr_o = ptr, wr_dat_o = byte), ptr <= ptr + 1 mod MEM_DEPTH.
    - Returns to WR_BYTE.
  - RD_BYTE: drives each bit on SCL fall. After the 8th SCL fall, release SDA -> RD_ACK. ptr <= ptr + 1 mod MEM_DEPTH when the byte is loaded.
  - RD_ACK: samples SDA on SCL rise.
    - 0 (ACK) -> reload from mem[ptr], RD_BYTE.
    - 1 (NACK) -> IGNORE (release until STOP/START).
- Every data byte is ACKed; there is no write NACK.
- Reset values: sda_o = 1, busy_o = 0, wr_stb_o = 0, wr_adr_o = 0, wr_dat_o = 0, state IDLE, ptr = 0, first_byte = 1, all mem bytes = 8'h00, synchronizers = 1.

## Timing
- Input-to-decision latency: 3 clk (2 sync + 1 edge register).
- sda_o updates 4 clk after the raw SCL falling edge. With SCL low ≥ 4 clk, data is valid before the next rise.
- wr_stb_o is asserted in the clk after the WR_ACK SCL rising edge is detected, for exactly 1 clk.
- Simultaneous START/STOP detection and a data edge: START/STOP wins. A partial byte is discarded with no wr_stb_o.
- rst_i mid-transfer: next clk all reset values apply and SDA is released. Memory is cleared.
- Pointer wrap: 4'hF + 1 -> 4'h0, for both read and write.

## Test plan
- Write 8'h44, ptr 8'h03, data 8'hA5, 8'h5A, STOP:
  - ACK on all 4 bytes.
  - wr_stb_o pulses twice: (3, A5) then (4, 5A).
  - busy_o falls at STOP.
- Write 8'h44, ptr 8'h03, repeated START, 8'h45, read 2 bytes (ACK then NACK), STOP:
  - Target returns A5, 5A.
  - SDA is released after the NACK.
  - No wr_stb_o pulses.
- Address 8'h46 (7'h23) with 3 following bytes:
  - sda_o stays 1 throughout.
  - busy_o stays 0.
  - No wr_stb_o.
- Write ptr 8'hFF (index F), then 3 data bytes 11, 22, 33:
  - Stores at F, 0, 1.
  - A later read from ptr 0 returns 22, 33.
- STOP after 4 bits of a data byte:
  - No wr_stb_o; state IDLE.
  - A next transaction to 8'h44 is ACKed normally.
- rst_i asserted for 1 clk while the target is driving an ACK:
  - sda_o = 1 on the next clk.
  - A read of ptr 0 after re-addressing returns 8'h00.
